// File: rtl/int_issue_queue.sv
// Integer issue queue: collects dispatched micro-ops, tracks source readiness from
// writeback wakeups, and issues the oldest ready entry by ROB age.
module int_issue_queue #(
  parameter int DEPTH      = 8,
  parameter int ENQ_WIDTH  = 2,
  parameter int WB_WIDTH   = 4,
  parameter int PREG_WIDTH = 7,
  parameter int ROB_WIDTH  = 6,
  parameter int DATA_WIDTH = 64
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [ENQ_WIDTH-1:0]                   enq_en,
  input  logic [ENQ_WIDTH-1:0][PREG_WIDTH-1:0]   enq_rs1,
  input  logic [ENQ_WIDTH-1:0][PREG_WIDTH-1:0]   enq_rs2,
  input  logic [ENQ_WIDTH-1:0]                   enq_rs1v,
  input  logic [ENQ_WIDTH-1:0]                   enq_rs2v,
  input  logic [ENQ_WIDTH-1:0][ROB_WIDTH:0]      enq_rob,
  input  logic [ENQ_WIDTH-1:0][DATA_WIDTH-1:0]   enq_data,
  output logic                                   full,
  input  logic [WB_WIDTH-1:0]                    wakeup_en,
  input  logic [WB_WIDTH-1:0][PREG_WIDTH-1:0]    wakeup_preg,
  output logic                                   iss_valid,
  input  logic                                   iss_ready,
  output logic [PREG_WIDTH-1:0]                  iss_rs1,
  output logic [PREG_WIDTH-1:0]                  iss_rs2,
  output logic [ROB_WIDTH:0]                     iss_rob,
  output logic [DATA_WIDTH-1:0]                  iss_data,
  input  logic                                   redirect,
  input  logic [ROB_WIDTH:0]                     redirect_idx
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = IDX_W + 1;

  logic [DEPTH-1:0]                  valid_q, valid_d;
  logic [DEPTH-1:0]                  rdy1_q, rdy1_d;
  logic [DEPTH-1:0]                  rdy2_q, rdy2_d;
  logic [DEPTH-1:0][PREG_WIDTH-1:0]  rs1_q, rs1_d;
  logic [DEPTH-1:0][PREG_WIDTH-1:0]  rs2_q, rs2_d;
  logic [DEPTH-1:0][ROB_WIDTH:0]     rob_q, rob_d;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]  data_q, data_d;

  logic [CNT_W-1:0]                  free_cnt;
  logic                              sel_found;
  logic [IDX_W-1:0]                  sel_idx;
  logic [ROB_WIDTH:0]                sel_rob;
  logic                              deq;
  logic                              alloc_ok;
  logic [DEPTH-1:0]                  taken;
  logic [ENQ_WIDTH-1:0]              slot_vld;
  logic [ENQ_WIDTH-1:0][IDX_W-1:0]   slot_idx;

  // Age compare with the dir bit resolving wrap-around of the ROB index.
  function automatic logic older(input logic [ROB_WIDTH:0] a, input logic [ROB_WIDTH:0] b);
    if (a[ROB_WIDTH] == b[ROB_WIDTH]) older = a[ROB_WIDTH-1:0] < b[ROB_WIDTH-1:0];
    else                              older = a[ROB_WIDTH-1:0] > b[ROB_WIDTH-1:0];
  endfunction

  function automatic logic woken(input logic [PREG_WIDTH-1:0]               tag,
                                 input logic [WB_WIDTH-1:0]                 en,
                                 input logic [WB_WIDTH-1:0][PREG_WIDTH-1:0] preg);
    woken = 1'b0;
    for (int k = 0; k < WB_WIDTH; k++) begin
      if (en[k] && (preg[k] == tag)) woken = 1'b1;
    end
  endfunction

  always_comb begin
    free_cnt = '0;
    for (int i = 0; i < DEPTH; i++) free_cnt = free_cnt + CNT_W'(!valid_q[i]);
  end

  assign full = free_cnt < CNT_W'(ENQ_WIDTH);

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_rob   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && rdy1_q[i] && rdy2_q[i] && (!sel_found || older(rob_q[i], sel_rob))) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_rob   = rob_q[i];
      end
    end
  end

  assign iss_rs1   = rs1_q[sel_idx];
  assign iss_rs2   = rs2_q[sel_idx];
  assign iss_rob   = sel_rob;
  assign iss_data  = data_q[sel_idx];
  // A selected entry at or past the flush point is being killed, so it must not fire.
  assign iss_valid = sel_found && !(redirect && !older(sel_rob, redirect_idx));
  assign deq       = iss_valid && iss_ready;
  assign alloc_ok  = !full && !redirect;

  always_comb begin
    taken    = valid_q;
    slot_vld = '0;
    slot_idx = '0;
    for (int p = 0; p < ENQ_WIDTH; p++) begin
      if (enq_en[p] && alloc_ok) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (!taken[i] && !slot_vld[p]) begin
            slot_vld[p] = 1'b1;
            slot_idx[p] = IDX_W'(i);
          end
        end
        if (slot_vld[p]) taken[slot_idx[p]] = 1'b1;
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    rdy1_d  = rdy1_q;
    rdy2_d  = rdy2_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rob_d   = rob_q;
    data_d  = data_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) begin
        if (woken(rs1_q[i], wakeup_en, wakeup_preg)) rdy1_d[i] = 1'b1;
        if (woken(rs2_q[i], wakeup_en, wakeup_preg)) rdy2_d[i] = 1'b1;
      end
    end
    if (deq) valid_d[sel_idx] = 1'b0;
    if (redirect) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!older(rob_q[i], redirect_idx)) valid_d[i] = 1'b0;
      end
    end
    for (int p = 0; p < ENQ_WIDTH; p++) begin
      if (slot_vld[p]) begin
        valid_d[slot_idx[p]] = 1'b1;
        rs1_d[slot_idx[p]]   = enq_rs1[p];
        rs2_d[slot_idx[p]]   = enq_rs2[p];
        rdy1_d[slot_idx[p]]  = enq_rs1v[p] || woken(enq_rs1[p], wakeup_en, wakeup_preg);
        rdy2_d[slot_idx[p]]  = enq_rs2v[p] || woken(enq_rs2[p], wakeup_en, wakeup_preg);
        rob_d[slot_idx[p]]   = enq_rob[p];
        data_d[slot_idx[p]]  = enq_data[p];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      rdy1_q  <= '0;
      rdy2_q  <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rob_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      rdy1_q  <= rdy1_d;
      rdy2_q  <= rdy2_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rob_q   <= rob_d;
      data_q  <= data_d;
    end
  end

endmodule
